// File: rtl/nnrv_pkg.sv
// Shared definitions for the nnrv UART transmitter: register map, STATUS bits,
// transmitter FSM encoding and the bus request bundle.
package nnrv_pkg;

  // Register word index, taken from i_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic        sel;
    logic        we;
    logic [1:0]  word;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/nnrv_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module nnrv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nnrv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, baud-counted shifter FSM,
// STATUS/DIV/CTRL registers and a level drain interrupt.
module nnrv_uart_tx
  import nnrv_pkg::*;
#(
  parameter int DIV_RST    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_irq
);

  bus_req_t req;
  logic     wr_data, wr_status, wr_div, wr_ctrl;

  assign req = '{sel: i_sel, we: i_we, word: i_addr[3:2], wdata: i_wdata};

  assign wr_data   = req.sel & req.we & (req.word == REG_DATA);
  assign wr_status = req.sel & req.we & (req.word == REG_STATUS);
  assign wr_div    = req.sel & req.we & (req.word == REG_DIV);
  assign wr_ctrl   = req.sel & req.we & (req.word == REG_CTRL);

  logic unused_ok;
  assign unused_ok = ^{i_addr[1:0], req.wdata[31:16]};

  // ---------------------------------------------------------------- FIFO
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  nnrv_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (req.wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ----------------------------------------------------------- registers
  logic [15:0] div_q;
  logic        irq_en_q;
  logic        ovf_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q    <= 16'(DIV_RST);
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_div)  div_q    <= req.wdata[15:0];
      if (wr_ctrl) irq_en_q <= req.wdata[0];
      // A pop in the same cycle makes room, so that push is not an overflow.
      if (wr_data & fifo_full & ~fifo_pop)        ovf_q <= 1'b1;
      else if (wr_status & req.wdata[ST_OVF])     ovf_q <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- FSM
  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        bit_end;

  assign bit_end = (cnt_q == div_lat_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      div_lat_q <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          sh_d      = fifo_rdata;
          div_lat_d = div_q;
          cnt_d     = '0;
          bit_d     = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sh_d      = fifo_rdata;
            div_lat_d = div_q;
            bit_d     = '0;
            state_d   = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Decoded from the async-reset state so the line returns high on reset.
  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      TX_START: o_tx = 1'b0;
      TX_DATA:  o_tx = sh_q[0];
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_busy = (state_q != TX_IDLE) | ~fifo_empty;
  assign o_irq  = irq_en_q & ~o_busy;

  // ------------------------------------------------------------ readback
  always_comb begin
    o_rdata = '0;
    case (req.word)
      REG_STATUS: begin
        o_rdata[ST_EMPTY]  = fifo_empty;
        o_rdata[ST_FULL]   = fifo_full;
        o_rdata[ST_ACTIVE] = (state_q != TX_IDLE);
        o_rdata[ST_OVF]    = ovf_q;
      end
      REG_DIV:  o_rdata[15:0] = div_q;
      REG_CTRL: o_rdata[0]    = irq_en_q;
      default:  o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nnrv_uart_tx.sv
// Bench for nnrv_uart_tx: exact serial waveforms from a bit-time model plus a
// free-running UART receiver that decodes bytes off the line.
module tb_nnrv_uart_tx;

  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;
  localparam int HN = 65536;

  logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, busy, irq;

  int total = 0, bad = 0;
  int cyc = 0;
  logic tx_hist   [HN];
  logic busy_hist [HN];
  logic [7:0] exp_q[$];
  logic [7:0] rxq[$];
  int mon_div = 16;
  int frame_err = 0;

  nnrv_uart_tx #(.DIV_RST(16), .FIFO_DEPTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_tx(tx), .o_busy(busy), .o_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // hist[c] holds the line level after posedge number c
  always @(negedge clk) begin
    tx_hist[cyc % HN]   = tx;
    busy_hist[cyc % HN] = busy;
  end

  // Receiver: start on a low sample, then sample each bit mid-period
  initial begin : mon
    logic [7:0] b;
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        d = mon_div;
        b = '0;
        repeat (d / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (d + 1) @(negedge clk);
          b[j] = tx;
        end
        repeat (d + 1) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(b);
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    e = cyc;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Frame offset k: bit time k/(d+1); 0 = start, 1..8 = data LSB first, 9 = stop
  function automatic logic exp_bit(input logic [7:0] b, input int d, input int k);
    int idx;
    idx = k / (d + 1);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic int wave_mismatch(input int e, input int d, input int n);
    int flen;
    flen = 10 * (d + 1);
    for (int k = 0; k < n * flen; k++)
      if (tx_hist[(e + 1 + k) % HN] !== exp_bit(exp_q[k / flen], d, k % flen)) return k;
    return -1;
  endfunction

  task automatic test_reset;
    logic [31:0] r;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (irq !== 1'b0)  begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst_n = 1'b1;
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h1)  begin bad++; $display("FAIL reset_status: got %h want 1", r); end
    bus_read(A_DIV, r);
    total++; if (r !== 32'd16) begin bad++; $display("FAIL reset_div: got %h want 10", r); end
    bus_read(A_CTRL, r);
    total++; if (r !== 32'h0)  begin bad++; $display("FAIL reset_ctrl: got %h want 0", r); end
    bus_read(A_DATA, r);
    total++; if (r !== 32'h0)  begin bad++; $display("FAIL reset_data: got %h want 0", r); end
  endtask

  task automatic test_single;
    int e, m;
    logic [31:0] r;
    bus_write(A_DIV, 32'd3, e);
    mon_div = 3; rxq.delete();
    bus_write(A_DATA, 32'h55, e);
    exp_q.delete(); exp_q.push_back(8'h55);
    wait_cyc(e + 43);
    total++; if (tx_hist[e % HN] !== 1'b1) begin bad++; $display("FAIL single_prestart: got %b want 1", tx_hist[e % HN]); end
    m = wave_mismatch(e, 3, 1);
    total++; if (m >= 0) begin bad++; $display("FAIL single_wave: cycle %0d got %b want %b", m, tx_hist[(e+1+m) % HN], exp_bit(8'h55, 3, m)); end
    total++; if (busy_hist[(e + 40) % HN] !== 1'b1 || busy_hist[(e + 41) % HN] !== 1'b0)
      begin bad++; $display("FAIL single_busy: last=%b after=%b want 1,0", busy_hist[(e+40) % HN], busy_hist[(e+41) % HN]); end
    total++; if (rxq.size() != 1 || rxq[0] !== 8'h55) begin bad++; $display("FAIL single_rx: got %0d bytes first %h want 55", rxq.size(), rxq.size() ? rxq[0] : 8'h0); end
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL single_status: got %h want 1", r); end
  endtask

  task automatic test_random_frames;
    int e, m, d;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      d = (it == 0) ? 0 : int'($urandom_range(0, 4));
      b = 8'($urandom);
      bus_write(A_DIV, 32'(d), e);
      mon_div = d; rxq.delete();
      bus_write(A_DATA, {24'h0, b}, e);
      exp_q.delete(); exp_q.push_back(b);
      wait_cyc(e + 10 * (d + 1) + 3);
      m = wave_mismatch(e, d, 1);
      total++; if (m >= 0) begin bad++; $display("FAIL rand_wave: div %0d byte %h cycle %0d got %b want %b", d, b, m, tx_hist[(e+1+m) % HN], exp_bit(b, d, m)); end
      total++; if (busy_hist[(e + 10*(d+1) + 1) % HN] !== 1'b0) begin bad++; $display("FAIL rand_busy: div %0d got 1 want 0", d); end
    end
  endtask

  task automatic test_div_midframe;
    int e, e2, m;
    logic [31:0] r;
    bus_write(A_DIV, 32'd1, e);
    mon_div = 1;
    bus_write(A_DATA, 32'hC3, e);
    bus_write(A_DIV, 32'd2, e2);
    exp_q.delete(); exp_q.push_back(8'hC3);
    wait_cyc(e + 23);
    m = wave_mismatch(e, 1, 1);
    total++; if (m >= 0) begin bad++; $display("FAIL midframe_old_div: cycle %0d got %b want %b", m, tx_hist[(e+1+m) % HN], exp_bit(8'hC3, 1, m)); end
    bus_read(A_DIV, r);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL midframe_div_rd: got %h want 2", r); end
    mon_div = 2;
    bus_write(A_DATA, 32'h3C, e);
    exp_q.delete(); exp_q.push_back(8'h3C);
    wait_cyc(e + 33);
    m = wave_mismatch(e, 2, 1);
    total++; if (m >= 0) begin bad++; $display("FAIL midframe_new_div: cycle %0d got %b want %b", m, tx_hist[(e+1+m) % HN], exp_bit(8'h3C, 2, m)); end
  endtask

  task automatic test_back_to_back;
    int e, ex, m, d;
    logic [7:0] b;
    bus_write(A_DIV, 32'd1, e);
    mon_div = 1; rxq.delete();
    bus_write(A_DATA, 32'hA5, e);
    bus_write(A_DATA, 32'h0F, ex);
    exp_q.delete(); exp_q.push_back(8'hA5); exp_q.push_back(8'h0F);
    wait_cyc(e + 43);
    m = wave_mismatch(e, 1, 2);
    total++; if (m >= 0) begin bad++; $display("FAIL b2b_wave: cycle %0d got %b want %b", m, tx_hist[(e+1+m) % HN], exp_bit(exp_q[m/20], 1, m % 20)); end
    total++; if (rxq.size() != 2 || rxq[0] !== 8'hA5 || rxq[1] !== 8'h0F)
      begin bad++; $display("FAIL b2b_rx: got %0d bytes want a5,0f", rxq.size()); end
    total++; if (busy_hist[(e + 40) % HN] !== 1'b1 || busy_hist[(e + 41) % HN] !== 1'b0)
      begin bad++; $display("FAIL b2b_busy: last=%b after=%b want 1,0", busy_hist[(e+40) % HN], busy_hist[(e+41) % HN]); end
    // random burst of three at a random divider
    d = int'($urandom_range(0, 3));
    bus_write(A_DIV, 32'(d), e);
    mon_div = d; rxq.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(A_DATA, {24'h0, b}, ex);
      if (i == 0) e = ex;
    end
    wait_cyc(e + 30 * (d + 1) + 3);
    m = wave_mismatch(e, d, 3);
    total++; if (m >= 0) begin bad++; $display("FAIL burst_wave: div %0d cycle %0d got %b", d, m, tx_hist[(e+1+m) % HN]); end
    total++; if (rxq.size() != 3 || rxq[0] !== exp_q[0] || rxq[1] !== exp_q[1] || rxq[2] !== exp_q[2])
      begin bad++; $display("FAIL burst_rx: got %0d bytes want 3", rxq.size()); end
  endtask

  task automatic test_overflow;
    int e, fe, n;
    logic [31:0] r;
    bus_write(A_DIV, 32'd100, e);
    mon_div = 100; rxq.delete(); fe = frame_err;
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'(i), e);
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h6) begin bad++; $display("FAIL ovf_full: got %h want 6", r); end
    bus_write(A_DATA, 32'h09, e);
    bus_read(A_STATUS, r);
    total++; if (r !== 32'hE) begin bad++; $display("FAIL ovf_set: got %h want e", r); end
    bus_write(A_STATUS, 32'h8, e);
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h6) begin bad++; $display("FAIL ovf_clear: got %h want 6", r); end
    n = 0;
    while (busy && n < 12000) begin @(negedge clk); n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_drain: busy still %b after %0d cycles", busy, n); end
    repeat (4) @(negedge clk);
    n = 0;
    for (int i = 0; i < 9; i++) if (i < rxq.size() && rxq[i] === 8'(i)) n++;
    total++; if (rxq.size() != 9 || n != 9) begin bad++; $display("FAIL ovf_rx: got %0d bytes %0d matching want 9", rxq.size(), n); end
    total++; if (frame_err != fe) begin bad++; $display("FAIL ovf_stopbits: got %0d errors want 0", frame_err - fe); end
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL ovf_status_end: got %h want 1", r); end
  endtask

  task automatic test_irq;
    int e, e2;
    logic [31:0] r;
    bus_write(A_DIV, 32'd2, e);
    mon_div = 2;
    bus_write(A_CTRL, 32'h1, e);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle: got %b want 1", irq); end
    bus_write(A_DATA, 32'hFF, e);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_start: got %b want 0", irq); end
    wait_cyc(e + 30);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0 at frame cycle 29", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1 at frame cycle 30", irq); end
    // reset in the middle of a 0x00 frame with another byte queued
    bus_write(A_DATA, 32'h00, e);
    bus_write(A_DATA, 32'h5A, e2);
    wait_cyc(e + 13);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_pre: got %b want 0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL rstmid_busy_irq: busy=%b irq=%b want 0,0", busy, irq); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_STATUS, r);
    total++; if (r !== 32'h1)  begin bad++; $display("FAIL rstmid_status: got %h want 1", r); end
    bus_read(A_DIV, r);
    total++; if (r !== 32'd16) begin bad++; $display("FAIL rstmid_div: got %h want 10", r); end
    e = cyc;
    wait_cyc(e + 40);
    @(negedge clk);
    e2 = 0;
    for (int c = e; c < e + 40; c++) if (tx_hist[c % HN] !== 1'b1) e2++;
    total++; if (e2 != 0) begin bad++; $display("FAIL rstmid_discard: %0d low cycles after reset want 0", e2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_frames();
    test_div_midframe();
    test_back_to_back();
    test_overflow();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nnrv_uart_tx.md
# nnrv_uart_tx

Memory-mapped 8N1 UART transmitter on the nnrv core's data bus, downstream of the load/store path, driving a serial pin next to `o_led` in `nnrv_top`. Store bytes are queued in a small FIFO and serialised by a baud-counter state machine. Status and control registers let firmware poll for space or completion. An interrupt line signals that the transmitter is drained. The block gives the bench and the board a byte-level result channel in addition to the register dump.

## Interface
- `DIV_RST`, 16: reset value of the baud divider; bit time = DIV+1 clocks.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_sel`  in  1  peripheral selected by the address decoder this cycle.
- `i_we`  in  1  write strobe; valid only with `i_sel`.
- `i_addr`  in  4  byte offset; bits [1:0] are ignored.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  read data; combinational, same cycle.
- `o_tx`  out  1  serial line; idle high.
- `o_busy`  out  1  frame in progress or FIFO non-empty.
- `o_irq`  out  1  drain interrupt.

## Operation
- Register map:
  - 0x0 DATA: write pushes `i_wdata[7:0]`; reads 0.
  - 0x4 STATUS, read-only except bit3: bit0 empty, bit1 full, bit2 shifter active, bit3 overflow (sticky; cleared by writing 1 to bit3).
  - 0x8 DIV: bits[15:0], read/write.
  - 0xC CTRL: bit0 irq_en, read/write.
  - Unused bits read 0.
- Push when full: byte dropped, overflow set, FIFO unchanged.
- Push and pop in the same cycle while full: both take effect; no overflow.
- FSM states IDLE, START, DATA, STOP:
  - IDLE→START when FIFO non-empty. The FIFO pops, the byte is loaded into the shifter, and DIV is latched.
  - START: `o_tx`=0 for DIV+1 cycles.
  - DATA: 8 bits, LSB first, each DIV+1 cycles. A 3-bit counter wraps 7→0 into STOP.
  - STOP: `o_tx`=1 for DIV+1 cycles. Then go to START if the FIFO is non-empty (back-to-back, no idle gap), else IDLE.
- A DIV write mid-frame affects only the next frame. DIV=0 gives 1 clock per bit.
- `o_busy` = (state≠IDLE) | !empty.
- `o_irq` = irq_en & !`o_busy`. It is level-sensitive and is never asserted during reset.
- Reset values:
  - `o_tx`=1, `o_busy`=0, `o_irq`=0, `o_rdata` as decoded.
  - FIFO empty, overflow=0, DIV=`DIV_RST`, irq_en=0, state IDLE.
- Reset mid-frame: `o_tx` goes high asynchronously and queued bytes are discarded.

## Timing
- DATA write sampled at edge E with FIFO empty and state IDLE:
  - FSM enters START at edge E+1.
  - `o_tx` falls after E+1.
  - First data bit starts at E+1+(DIV+1).
- Frame length is exactly 10·(DIV+1) cycles. Consecutive queued bytes have frames starting 10·(DIV+1) apart.
- STATUS empty/full reflect pushes and pops one edge after they occur.
- Reads have no side effects.

## Structure
- Shared package `nnrv_pkg`: register offsets, the STATUS bit indices, and FSM state encodings.
- Sub-module `nnrv_fifo`: synchronous FIFO with parameters width 8 and `FIFO_DEPTH`. It has push/pop/full/empty, simultaneous push+pop, and wrap-around pointers with an extra MSB.
- `nnrv_top` maps the block at 0x1000_0000 and exposes `o_tx`.

## Test plan
- Reset check: hold `i_rst_n`=0, then release.
  - Expect `o_tx`=1, STATUS=0x1, DIV=16, `o_irq`=0.
- Single byte: DIV=3, write 0x55.
  - `o_tx` sequence 0,1,0,1,0,1,0,1,0,1, each level 4 cycles (40 cycles total).
  - `o_busy` falls after the stop bit.
- Back-to-back: DIV=1, write 0xA5 then 0x0F.
  - Two frames of 20 cycles each with no idle high between them.
  - Decoded bytes 0xA5, 0x0F.
- Overflow: DIV=100, write 10 bytes 0x00..0x09.
  - full=1 after 9 writes (one byte is already in the shifter).
  - 10th write is dropped and STATUS bit3=1.
  - Writing 0x8 to STATUS clears bit3.
  - Serial output is 0x00..0x08.
- Interrupt and reset mid-frame:
  - irq_en=1, write 0xFF, DIV=2: `o_irq` rises 30 cycles after the frame starts.
  - Repeat with `i_rst_n` pulsed low at cycle 12: `o_tx`=1 immediately and STATUS=0x1.
